// File: rtl/pc_pkg.sv
// Shared types for the fetch-address sequencer: operation encoding and
// the fixed-priority request decoder.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_RET    = 3'd1,
    OP_CALL   = 3'd2,
    OP_JUMP   = 3'd3,
    OP_BRANCH = 3'd4,
    OP_STEP   = 3'd5
  } pc_op_e;

  // Collapse the request bits to a single operation.
  // Priority: stall > ret > call > jump > branch > step.
  // Reset is handled by the flops and is not part of this decode.
  function automatic pc_op_e pc_decode(
    input logic stall,
    input logic ret,
    input logic call,
    input logic jump,
    input logic branch
  );
    pc_op_e op;
    if (stall)       op = OP_HOLD;
    else if (ret)    op = OP_RET;
    else if (call)   op = OP_CALL;
    else if (jump)   op = OP_JUMP;
    else if (branch) op = OP_BRANCH;
    else             op = OP_STEP;
    return op;
  endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack. top_q points at the most recent entry;
// a push when full simply advances over the oldest entry, so the oldest
// return address is lost while the count saturates at DEPTH.
// The caller never asserts push and pop together and never pops when empty.
module return_address_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_push_data,
  output logic [WIDTH-1:0]             o_top,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    top_inc, top_dec;

  assign top_inc = (top_q == PW'(DEPTH-1)) ? '0 : top_q + PW'(1);
  assign top_dec = (top_q == '0) ? PW'(DEPTH-1) : top_q - PW'(1);

  assign o_top   = mem_q[top_q];
  assign o_count = count_q;
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);

  // Next pointer, count and storage for push / pop.
  always_comb begin
    mem_d   = mem_q;
    top_d   = top_q;
    count_d = count_q;
    if (i_push) begin
      top_d        = top_inc;
      mem_d[top_inc] = i_push_data;
      if (!o_full) count_d = count_q + CW'(1);
    end else if (i_pop) begin
      top_d   = top_dec;
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and count; reset empties the stack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset: after reset nothing is reachable until pushed.
  always_ff @(posedge i_clk) begin
    if (!i_rst) mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter: registered address with step, stall, jump,
// PC-relative branch and call/return through a return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH      = 32,
  parameter logic [WIDTH-1:0]  RESET_ADDR = '0,
  parameter int unsigned       STEP       = 4,
  parameter int unsigned       RAS_DEPTH  = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_stall,
  input  logic                           i_jump,
  input  logic                           i_branch,
  input  logic                           i_call,
  input  logic                           i_ret,
  input  logic [WIDTH-1:0]               i_address,
  input  logic [WIDTH-1:0]               i_offset,
  output logic [WIDTH-1:0]               o_address,
  output logic [$clog2(RAS_DEPTH+1)-1:0] o_ras_count,
  output logic                           o_ras_overflow,
  output logic                           o_ras_underflow
);

  pc_op_e           op;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] seq_addr;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ras_push, ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic             ras_full, ras_empty;

  assign op       = pc_decode(i_stall, i_ret, i_call, i_jump, i_branch);
  assign seq_addr = addr_q + WIDTH'(STEP);

  // Only a winning call pushes; a ret on an empty stack does not pop.
  assign ras_push = (op == OP_CALL);
  assign ras_pop  = (op == OP_RET) && !ras_empty;

  return_address_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (ras_push),
    .i_pop       (ras_pop),
    .i_push_data (seq_addr),
    .o_top       (ras_top),
    .o_count     (o_ras_count),
    .o_full      (ras_full),
    .o_empty     (ras_empty)
  );

  // Next-address mux and stack error pulses.
  always_comb begin
    addr_d = seq_addr;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    case (op)
      OP_HOLD:   addr_d = addr_q;
      OP_RET: begin
        if (ras_empty) begin
          addr_d = seq_addr;
          unf_d  = 1'b1;
        end else begin
          addr_d = ras_top;
        end
      end
      OP_CALL: begin
        addr_d = i_address;
        ovf_d  = ras_full;
      end
      OP_JUMP:   addr_d = i_address;
      OP_BRANCH: addr_d = addr_q + i_offset;
      default:   addr_d = seq_addr;
    endcase
  end

  // Address and pulse registers; reset overrides any request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q <= RESET_ADDR;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign o_address       = addr_q;
  assign o_ras_overflow  = ovf_q;
  assign o_ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer (WIDTH=32, STEP=4,
// RAS_DEPTH=4, RESET_ADDR=0x100) plus hand sequences for stack overflow.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0, stall = 1'b0, jump = 1'b0, branch = 1'b0;
  logic        call = 1'b0, ret = 1'b0;
  logic [31:0] address = '0, offset = '0;
  logic [31:0] o_address;
  logic [2:0]  o_ras_count;
  logic        o_ras_overflow, o_ras_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH      (32),
    .RESET_ADDR (32'h100),
    .STEP       (4),
    .RAS_DEPTH  (4)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_stall         (stall),
    .i_jump          (jump),
    .i_branch        (branch),
    .i_call          (call),
    .i_ret           (ret),
    .i_address       (address),
    .i_offset        (offset),
    .o_address       (o_address),
    .o_ras_count     (o_ras_count),
    .o_ras_overflow  (o_ras_overflow),
    .o_ras_underflow (o_ras_underflow)
  );

  typedef struct {
    string       name;
    logic        rst, stall, ret, call, jump, branch;
    logic [31:0] addr, off;
    logic [31:0] e_addr;
    int          e_cnt;
    logic        e_ovf, e_unf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of requests, then compare all outputs after the edge.
  task automatic cyc(input vec_t v);
    rst = v.rst; stall = v.stall; ret = v.ret; call = v.call;
    jump = v.jump; branch = v.branch; address = v.addr; offset = v.off;
    @(posedge clk);
    #1;
    chk({v.name, ".addr"},  o_address,               v.e_addr);
    chk({v.name, ".count"}, {29'd0, o_ras_count},    v.e_cnt);
    chk({v.name, ".ovf"},   {31'd0, o_ras_overflow}, {31'd0, v.e_ovf});
    chk({v.name, ".unf"},   {31'd0, o_ras_underflow},{31'd0, v.e_unf});
  endtask

  function automatic vec_t mk(input string nm, input logic [5:0] ctl,
                              input logic [31:0] a, input logic [31:0] o,
                              input logic [31:0] ea, input int ec,
                              input logic eo, input logic eu);
    vec_t v;
    // ctl = {rst, stall, ret, call, jump, branch}
    v.name = nm;
    {v.rst, v.stall, v.ret, v.call, v.jump, v.branch} = ctl;
    v.addr = a; v.off = o; v.e_addr = ea; v.e_cnt = ec;
    v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  localparam logic [5:0] RST = 6'b100000, STL = 6'b010000, RET = 6'b001000;
  localparam logic [5:0] CAL = 6'b000100, JMP = 6'b000010, BRA = 6'b000001;
  localparam logic [5:0] IDL = 6'b000000;

  initial begin
    tbl.push_back(mk("reset",       RST, 0, 0, 32'h100, 0, 0, 0));
    tbl.push_back(mk("step1",       IDL, 0, 0, 32'h104, 0, 0, 0));
    tbl.push_back(mk("step2",       IDL, 0, 0, 32'h108, 0, 0, 0));
    tbl.push_back(mk("step3",       IDL, 0, 0, 32'h10C, 0, 0, 0));
    tbl.push_back(mk("jmp200",      JMP, 32'h200, 0, 32'h200, 0, 0, 0));
    tbl.push_back(mk("br_neg",      BRA, 0, 32'hFFFFFFF0, 32'h1F0, 0, 0, 0));
    tbl.push_back(mk("jmp_top",     JMP, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 0, 0, 0));
    tbl.push_back(mk("step_wrap",   IDL, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk("jmp300",      JMP, 32'h300, 0, 32'h300, 0, 0, 0));
    tbl.push_back(mk("call1000",    CAL, 32'h1000, 0, 32'h1000, 1, 0, 0));
    tbl.push_back(mk("ret304",      RET, 0, 0, 32'h304, 0, 0, 0));
    tbl.push_back(mk("unf1",        RET, 0, 0, 32'h308, 0, 0, 1));
    tbl.push_back(mk("unf2",        RET, 0, 0, 32'h30C, 0, 0, 1));
    tbl.push_back(mk("unf_clear",   IDL, 0, 0, 32'h310, 0, 0, 0));
    tbl.push_back(mk("jmp4fc",      JMP, 32'h4FC, 0, 32'h4FC, 0, 0, 0));
    tbl.push_back(mk("call800",     CAL, 32'h800, 0, 32'h800, 1, 0, 0));
    tbl.push_back(mk("ret_call_jmp",RET|CAL|JMP, 32'h900, 0, 32'h500, 0, 0, 0));
    tbl.push_back(mk("no_push",     RET, 0, 0, 32'h504, 0, 0, 1));
    tbl.push_back(mk("call600",     CAL, 32'h600, 0, 32'h600, 1, 0, 0));
    tbl.push_back(mk("stall_jmp",   STL|JMP, 32'h700, 0, 32'h600, 1, 0, 0));
    tbl.push_back(mk("stall_ret",   STL|RET, 0, 0, 32'h600, 1, 0, 0));
    tbl.push_back(mk("ret508",      RET, 0, 0, 32'h508, 0, 0, 0));
    tbl.push_back(mk("call40",      CAL, 32'h40, 0, 32'h40, 1, 0, 0));
    tbl.push_back(mk("rst_call",    RST|CAL, 32'h80, 0, 32'h100, 0, 0, 0));
    tbl.push_back(mk("post_rst",    IDL, 0, 0, 32'h104, 0, 0, 0));
    tbl.push_back(mk("br_pos",      BRA, 0, 32'h20, 32'h124, 0, 0, 0));
    tbl.push_back(mk("branch_jmp",  JMP|BRA, 32'h10, 32'h40, 32'h10, 0, 0, 0));

    foreach (tbl[i]) cyc(tbl[i]);

    // Five nested calls from 0x10..0x50; the fifth overflows and drops 0x14.
    for (int i = 0; i < 5; i++) begin
      cyc(mk($sformatf("nest%0d", i), CAL, 32'h20 + 32'h10 * i, 0,
             32'h20 + 32'h10 * i, (i < 4) ? i + 1 : 4, (i == 4), 0));
    end
    cyc(mk("ret_a", RET, 0, 0, 32'h54, 3, 0, 0));
    cyc(mk("ret_b", RET, 0, 0, 32'h44, 2, 0, 0));
    cyc(mk("ret_c", RET, 0, 0, 32'h34, 1, 0, 0));
    cyc(mk("ret_d", RET, 0, 0, 32'h24, 0, 0, 0));
    cyc(mk("ret_e", RET, 0, 0, 32'h28, 0, 0, 1));

    // Six calls: fifth and sixth overflow on consecutive cycles; the
    // following ret must return the address pushed by the sixth call.
    for (int i = 0; i < 6; i++) begin
      cyc(mk($sformatf("fill%0d", i), CAL, 32'h1000 + 32'h10 * i, 0,
             32'h1000 + 32'h10 * i, (i < 4) ? i + 1 : 4, (i >= 4), 0));
    end
    cyc(mk("ret_wrap", RET, 0, 0, 32'h1044, 3, 0, 0));
    cyc(mk("ret_wrap2", RET, 0, 0, 32'h1034, 2, 0, 0));
    cyc(mk("idle_end", IDL, 0, 0, 32'h1038, 2, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised successor to the program counter: registered fetch address with sequential stepping, stall, absolute jump, PC-relative branch, and a hardware return-address stack (RAS) for call/return. Sits at the front of the fetch stage. The current address drives instruction memory; the control unit issues one control-flow request per cycle.

## Interface
- WIDTH, 32: address width in bits.
- RESET_ADDR, 0: value loaded into o_address on reset.
- STEP, 4: sequential increment, in bytes.
- RAS_DEPTH, 4: return-address stack entries (≥1).
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_stall  in  1  hold PC and RAS unchanged.
- i_jump  in  1  load i_address.
- i_branch  in  1  load o_address + i_offset.
- i_call  in  1  load i_address; push o_address + STEP.
- i_ret  in  1  load top of RAS; pop.
- i_address  in  WIDTH  absolute target for jump/call.
- i_offset  in  WIDTH  two's-complement branch offset.
- o_address  out  WIDTH  current fetch address (registered).
- o_ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries.
- o_ras_overflow  out  1  one-cycle pulse: call while RAS full.
- o_ras_underflow  out  1  one-cycle pulse: ret while RAS empty.

## Operation
- Exactly one operation per cycle, selected by fixed priority: reset > stall > ret > call > jump > branch > step (default).
- Lower-priority requests in the same cycle are ignored, not queued. This includes call+ret together: ret wins, and no push occurs.
- Step: next = o_address + STEP.
- Jump: next = i_address.
- Branch: next = o_address + i_offset.
- Call: next = i_address.
- Call, RAS push: push o_address + STEP; count += 1.
- Call, RAS full: oldest entry is discarded (circular), count stays at RAS_DEPTH, o_ras_overflow pulses. The jump is still taken.
- Ret, RAS not empty: next = top entry; count -= 1.
- Ret, RAS empty: treated as a step (next = o_address + STEP), count stays 0, o_ras_underflow pulses.
- Stall: o_address, RAS contents and count held. Both pulses low. All other requests that cycle are ignored.
- Arithmetic is modulo 2^WIDTH: wrap-around is silent and produces no flag. Addresses are not masked or alignment-checked.
- Reset: o_address = RESET_ADDR, count = 0, both pulses 0. RAS contents are don't-care and become unreachable.
- Reset mid-sequence overrides any request in the same cycle.

## Timing
- All outputs are registered. A request sampled at edge N is visible on o_address after edge N.
- No combinational path from inputs to outputs.
- o_ras_count, o_ras_overflow and o_ras_underflow update on the same edge as the o_address change they accompany.
- Pulses are high for exactly one cycle per offending request. Back-to-back offending requests give consecutive pulses.
- Throughput: one operation per cycle. A ret immediately after a call returns the just-pushed address.
- First sequential step after reset deassertion: RESET_ADDR → RESET_ADDR + STEP on the next edge.

## Structure
- Package pc_pkg holds:
  - enum pc_op_e: OP_HOLD, OP_RET, OP_CALL, OP_JUMP, OP_BRANCH, OP_STEP.
  - a priority-decode function mapping the request bits to pc_op_e.
- Sub-module return_address_stack holds:
  - parameters WIDTH and DEPTH;
  - ports for push, pop, push data, top, count, full and empty;
  - circular storage with a top pointer; discard-oldest on full push.
- pc_sequencer holds the address register, the next-address mux and the pulse registers.

## Test plan
All scenarios use WIDTH=32, STEP=4, RAS_DEPTH=4, RESET_ADDR=0x100.
- Reset, then 3 idle cycles → 0x100, 0x104, 0x108, 0x10C; count 0; no pulses.
- At 0x200, i_branch with i_offset=0xFFFFFFF0 → 0x1F0. At 0xFFFFFFFC, step → 0x00000000, no flag.
- At 0x300, call 0x1000 → 0x1000, count 1. Then ret → 0x304, count 0.
- Overflow: 5 nested calls from 0x10, 0x20, 0x30, 0x40, 0x50 → 5th call raises o_ras_overflow, count 4. Four rets return 0x54, 0x44, 0x34, 0x24. Fifth ret → underflow pulse, PC = 0x24 + 4.
- Priority, ret+call+jump together with RAS top 0x500 → 0x500, count decremented, no push.
- Priority, stall+jump → PC unchanged, count unchanged.
- i_rst asserted together with i_call → o_address 0x100, count 0, no overflow pulse.
